// File: rtl/space_shooter_pkg.sv
// Shared constants, state type and helpers for the space shooter enemy logic.
package space_shooter_pkg;

    localparam int NUM_SLOTS    = 8;
    localparam int SLOT_W       = 3;
    localparam int CNT_W        = 25;
    localparam int SCREEN_WIDTH = 640;
    localparam int ENEMY_WIDTH  = 32;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        COUNT = 2'd1,
        ALLOC = 2'd2
    } sched_state_t;

    function automatic logic [3:0] popcount8(input logic [7:0] v);
        logic [3:0] n;
        n = '0;
        for (int i = 0; i < 8; i++) begin
            n = n + {3'b000, v[i]};
        end
        return n;
    endfunction

endpackage

// File: rtl/free_slot_encoder.sv
// Lowest-index free slot finder over the enemy occupancy mask.
module free_slot_encoder
    import space_shooter_pkg::*;
(
    input  logic [NUM_SLOTS-1:0] mask,
    output logic [SLOT_W-1:0]    idx,
    output logic                 none_free
);

    // Scanning from the top down lets the lowest free index win.
    always_comb begin
        idx       = '0;
        none_free = &mask;
        for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
            if (!mask[i]) begin
                idx = SLOT_W'(i);
            end
        end
    end

endmodule

// File: rtl/enemy_slot_scheduler.sv
// Enemy spawn scheduler: owns the slot table, times spawns and ramps the
// spawn interval as kills accumulate.
module enemy_slot_scheduler
    import space_shooter_pkg::*;
#(
    parameter int NUM_SLOTS     = 8,
    parameter int INTERVAL_INIT = 30000000,
    parameter int INTERVAL_MIN  = 6000000,
    parameter int INTERVAL_STEP = 2000000,
    parameter int WAVE_KILLS    = 10,
    parameter int MIN_ENEMIES   = 2,
    parameter int X_OFFSET      = 64
)(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 enable,
    input  logic [3:0]           random_number,
    input  logic [NUM_SLOTS-1:0] kill,
    output logic [NUM_SLOTS-1:0] alive,
    output logic [3:0]           enemy_count,
    output logic                 spawn_valid,
    output logic [SLOT_W-1:0]    spawn_slot,
    output logic [9:0]           spawn_x,
    output logic [CNT_W-1:0]     interval
);

    localparam int KC_W = $clog2(WAVE_KILLS + NUM_SLOTS + 1);

    localparam logic [CNT_W-1:0] IV_INIT  = CNT_W'(INTERVAL_INIT);
    localparam logic [CNT_W-1:0] IV_MIN   = CNT_W'(INTERVAL_MIN);
    localparam logic [CNT_W-1:0] IV_STEP  = CNT_W'(INTERVAL_STEP);
    localparam logic [CNT_W-1:0] IV_FLOOR = CNT_W'(INTERVAL_MIN + INTERVAL_STEP);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [3:0]       FULL     = 4'(NUM_SLOTS);
    localparam logic [3:0]       MIN_CNT  = 4'(MIN_ENEMIES);
    localparam logic [9:0]       X_MAX    = 10'(SCREEN_WIDTH - ENEMY_WIDTH);

    sched_state_t            state, state_next;
    logic [CNT_W-1:0]        countdown, cd_next, cd_dec, reload_val, interval_dec;
    logic [KC_W-1:0]         kill_cnt, kill_sum;
    logic                    wave_done;
    logic                    do_spawn;
    logic [SLOT_W-1:0]       free_idx;
    logic                    none_free;
    logic [NUM_SLOTS-1:0]    accepted, spawn_mask, alive_next;
    logic [9:0]              x_raw;

    free_slot_encoder u_free_slot_encoder (
        .mask      (alive),
        .idx       (free_idx),
        .none_free (none_free)
    );

    // The ALLOC cycle is the first cycle of an interval, so spawns land
    // exactly `interval` cycles apart when the table has room.
    assign reload_val = (interval == '0) ? '0 : interval - CNT_ONE;
    assign cd_dec     = (countdown == '0) ? '0 : countdown - CNT_ONE;

    always_comb begin
        state_next = state;
        cd_next    = countdown;
        do_spawn   = 1'b0;
        if (!enable) begin
            state_next = IDLE;
        end else begin
            case (state)
                IDLE: begin
                    state_next = COUNT;
                    cd_next    = reload_val;
                end
                COUNT: begin
                    cd_next = cd_dec;
                    if (((cd_dec == '0) && (enemy_count != FULL)) ||
                        (enemy_count < MIN_CNT)) begin
                        state_next = ALLOC;
                    end
                end
                ALLOC: begin
                    do_spawn   = !none_free;
                    cd_next    = reload_val;
                    state_next = COUNT;
                end
                default: state_next = IDLE;
            endcase
        end
    end

    // Allocation reads the pre-kill mask, so a slot retired this cycle
    // stays empty until the following ALLOC.
    assign accepted     = kill & alive;
    assign spawn_mask   = do_spawn ? (NUM_SLOTS'(1) << free_idx) : '0;
    assign alive_next   = (alive & ~accepted) | spawn_mask;
    assign kill_sum     = kill_cnt + KC_W'(popcount8(accepted));
    assign wave_done    = kill_sum >= KC_W'(WAVE_KILLS);
    assign interval_dec = (interval >= IV_FLOOR) ? interval - IV_STEP : IV_MIN;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            countdown   <= '0;
            alive       <= '0;
            enemy_count <= '0;
            kill_cnt    <= '0;
            interval    <= IV_INIT;
        end else begin
            state       <= state_next;
            countdown   <= cd_next;
            alive       <= alive_next;
            enemy_count <= popcount8(alive_next);
            if (wave_done) begin
                kill_cnt <= kill_sum - KC_W'(WAVE_KILLS);
                interval <= interval_dec;
            end else begin
                kill_cnt <= kill_sum;
            end
        end
    end

    assign x_raw       = {1'b0, random_number, 5'b00000} + 10'(X_OFFSET);
    assign spawn_valid = do_spawn;
    assign spawn_slot  = do_spawn ? free_idx : '0;
    assign spawn_x     = do_spawn ? ((x_raw > X_MAX) ? X_MAX : x_raw) : '0;

endmodule

// File: tb/tb_enemy_slot_scheduler.sv
// Scoreboard bench for enemy_slot_scheduler using shortened interval parameters.
module tb_enemy_slot_scheduler;

    logic       clk;
    logic       rst;
    logic       enable;
    logic [3:0] random_number;
    logic [7:0] kill;
    logic [7:0] alive;
    logic [3:0] enemy_count;
    logic       spawn_valid;
    logic [2:0] spawn_slot;
    logic [9:0] spawn_x;
    logic [24:0] interval;

    typedef struct {
        int         cyc;
        logic [2:0] slot;
        logic [9:0] x;
    } spawn_t;

    spawn_t exp_q[$];
    spawn_t cur;
    int cyc = 0;
    int checks = 0;
    int fails = 0;
    int e, k, d, r;

    enemy_slot_scheduler #(
        .NUM_SLOTS     (8),
        .INTERVAL_INIT (20),
        .INTERVAL_MIN  (8),
        .INTERVAL_STEP (5),
        .WAVE_KILLS    (3),
        .MIN_ENEMIES   (2),
        .X_OFFSET      (64)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .enable        (enable),
        .random_number (random_number),
        .kill          (kill),
        .alive         (alive),
        .enemy_count   (enemy_count),
        .spawn_valid   (spawn_valid),
        .spawn_slot    (spawn_slot),
        .spawn_x       (spawn_x),
        .interval      (interval)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            fails++;
            $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)",
                     name, actual, expected, cyc);
        end
    endtask

    task automatic applyStimulus(input logic en, input logic [7:0] k_mask,
                                 input logic [3:0] rn);
        enable        = en;
        kill          = k_mask;
        random_number = rn;
    endtask

    task automatic pulseKill(input logic en, input logic [7:0] k_mask,
                             input logic [3:0] rn);
        applyStimulus(en, k_mask, rn);
        @(posedge clk);
        #1;
        applyStimulus(en, 8'h00, rn);
    endtask

    task automatic waitUntil(input int c);
        while (cyc < c) begin
            @(posedge clk);
            #1;
        end
    endtask

    function automatic void pushSpawn(input int c, input int slot, input int x);
        spawn_t s;
        s.cyc  = c;
        s.slot = 3'(slot);
        s.x    = 10'(x);
        exp_q.push_back(s);
    endfunction

    // Monitor: every spawn command must match the next expected one.
    always @(negedge clk) begin
        if (!rst && spawn_valid) begin
            if (exp_q.size() == 0) begin
                checks++;
                fails++;
                $display("[TB] FAIL unexpected_spawn: got slot %0d at cycle %0d, expected no spawn",
                         spawn_slot, cyc);
            end else begin
                cur = exp_q.pop_front();
                checkOutput("spawn_cycle", 32'(cyc), 32'(cur.cyc));
                checkOutput("spawn_slot", 32'(spawn_slot), 32'(cur.slot));
                checkOutput("spawn_x", 32'(spawn_x), 32'(cur.x));
            end
        end
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not complete, expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst = 1'b1;
        applyStimulus(1'b0, 8'h00, 4'h0);
        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset_alive", 32'(alive), 32'h0);
        checkOutput("reset_count", 32'(enemy_count), 0);
        checkOutput("reset_valid", 32'(spawn_valid), 0);
        checkOutput("reset_interval", 32'(interval), 20);
        rst = 1'b0;

        // Fast fill of slots 0 and 1, then one spawn every 20 cycles.
        @(posedge clk);
        #1;
        e = cyc;
        applyStimulus(1'b1, 8'h00, 4'h3);
        pushSpawn(e + 2, 0, 160);
        pushSpawn(e + 4, 1, 160);
        pushSpawn(e + 24, 2, 160);
        for (int s = 3; s < 8; s++) pushSpawn(e + 24 + 20 * (s - 2), s, 544);
        waitUntil(e + 25);
        checkOutput("count_after_third", 32'(enemy_count), 3);
        applyStimulus(1'b1, 8'h00, 4'hF);

        // Table full with countdown expired: nothing spawns until a kill.
        waitUntil(e + 150);
        checkOutput("full_alive", 32'(alive), 32'hFF);
        checkOutput("full_count", 32'(enemy_count), 8);
        checkOutput("full_no_spawn", 32'(spawn_valid), 0);
        checkOutput("interval_before_waves", 32'(interval), 20);
        k = cyc;
        pushSpawn(k + 2, 4, 224);
        pulseKill(1'b1, 8'h10, 4'h5);
        checkOutput("kill4_alive", 32'(alive), 32'hEF);
        checkOutput("kill4_count", 32'(enemy_count), 7);
        waitUntil(k + 3);
        checkOutput("refill_alive", 32'(alive), 32'hFF);

        // Drop enable mid-countdown: no spawn, table retained.
        waitUntil(k + 4);
        d = cyc;
        applyStimulus(1'b0, 8'h00, 4'h5);
        waitUntil(d + 2);
        checkOutput("disabled_alive", 32'(alive), 32'hFF);
        checkOutput("disabled_valid", 32'(spawn_valid), 0);

        // Waves: kill_cnt 1 -> +3 (wave), +2 (wave), dead kill, +3 (wave).
        waitUntil(d + 3);
        pulseKill(1'b0, 8'h07, 4'h5);
        checkOutput("wave1_count", 32'(enemy_count), 5);
        checkOutput("wave1_alive", 32'(alive), 32'hF8);
        checkOutput("wave1_interval", 32'(interval), 15);
        pulseKill(1'b0, 8'h18, 4'h5);
        checkOutput("wave2_count", 32'(enemy_count), 3);
        checkOutput("wave2_interval", 32'(interval), 10);
        pulseKill(1'b0, 8'h01, 4'h5);
        checkOutput("dead_kill_count", 32'(enemy_count), 3);
        checkOutput("dead_kill_alive", 32'(alive), 32'hE0);
        checkOutput("dead_kill_interval", 32'(interval), 10);
        pulseKill(1'b0, 8'hE0, 4'h5);
        checkOutput("wave3_count", 32'(enemy_count), 0);
        checkOutput("wave3_interval", 32'(interval), 8);

        // Re-enable: fast fill, then the third spawn uses the ramped interval.
        r = cyc;
        applyStimulus(1'b1, 8'h00, 4'h7);
        pushSpawn(r + 2, 0, 288);
        pushSpawn(r + 4, 1, 288);
        waitUntil(r + 12);
        checkOutput("alloc_before_reset", 32'(spawn_valid), 1);
        checkOutput("alloc_slot_before_reset", 32'(spawn_slot), 2);

        // Reset in the middle of ALLOC clears everything at once.
        rst = 1'b1;
        #1;
        checkOutput("midreset_valid", 32'(spawn_valid), 0);
        checkOutput("midreset_slot", 32'(spawn_slot), 0);
        checkOutput("midreset_x", 32'(spawn_x), 0);
        checkOutput("midreset_alive", 32'(alive), 32'h0);
        checkOutput("midreset_count", 32'(enemy_count), 0);
        checkOutput("midreset_interval", 32'(interval), 20);
        repeat (2) @(posedge clk);
        #1;
        checkOutput("pending_spawns", 32'(exp_q.size()), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
